crc_stream: RTL and testbench
=============================

Name: crc_stream

Overview:
- Parametrised streaming CRC engine; generalises the fixed 8-bit, one-byte-per-beat CRC block.
- Configurable CRC width, polynomial, init value, bit reflection, final XOR and data-path width (BYTES lanes per beat).
- Frame-oriented with valid/ready handshake on input and result; residue check for receive-side frame validation.
- Sits between a byte-stream source (UART/packet framer) and a consumer of per-frame CRC results.

Parameters:
- WIDTH, 8: CRC width in bits; legal 8..32.
- POLYNOMIAL, 8'h07: generator polynomial, normal (non-reflected) form, implicit x^WIDTH term; WIDTH bits.
- INIT, 0: state loaded at reset and at start of each frame; WIDTH bits.
- REFLECT_IN, 0: 1 = each input byte is processed LSB first.
- REFLECT_OUT, 0: 1 = final state is bit-reversed before XOR_OUT.
- XOR_OUT, 0: XORed into the result after optional reflection; WIDTH bits.
- RESIDUE, 0: expected crc_o value when a frame including its own appended CRC is error-free; WIDTH bits.
- BYTES, 1: input lanes per beat; legal 1..8.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  8*BYTES  input data; lane k = data_i[8k+7:8k]; lane 0 is processed first.
- keep_i  in  BYTES  lane enables; only set lanes are processed, in ascending lane order.
- valid_i  in  1  beat valid.
- last_i  in  1  beat is the final beat of a frame.
- ready_o  out  1  engine accepts a beat when valid_i && ready_o.
- crc_o  out  WIDTH  final CRC of the last completed frame.
- match_o  out  1  crc_o == RESIDUE; meaningful only while crc_valid_o = 1.
- crc_valid_o  out  1  result is available.
- crc_ready_i  in  1  consumer takes the result when crc_valid_o && crc_ready_i.

Behaviour:
- Reset: state register = INIT; crc_o = 0; match_o = 0; crc_valid_o = 0; ready_o = 1.
- Reset wins over all other inputs and aborts a frame in progress; a pending result is discarded.
- Beat update (accepted beat):
  - next_state = state folded through each set lane in order.
  - Per byte: the byte is bit-reversed if REFLECT_IN, aligned to the state MSB, then shifted 8 times MSB-first with POLYNOMIAL.
  - Implemented as an unrolled combinational chain; no lookup table.
  - Beat with keep_i = 0 leaves state unchanged but still honours last_i.
- Accepted beat with last_i = 0: state <= next_state.
- Accepted beat with last_i = 1:
  - Next cycle: crc_o = (REFLECT_OUT ? reverse(next_state) : next_state) ^ XOR_OUT.
  - Next cycle: match_o = (that value == RESIDUE); crc_valid_o = 1.
  - State <= INIT, ready for the next frame.
  - Latency: result visible exactly one cycle after the last beat is accepted.
- Result handshake:
  - crc_o, match_o and crc_valid_o hold stable until crc_valid_o && crc_ready_i.
  - After the handshake, crc_valid_o = 0; crc_o and match_o keep their last values.
- Backpressure:
  - ready_o = !crc_valid_o || crc_ready_i, so at most one unconsumed result exists.
  - A last beat accepted in the same cycle as the result handshake loads the new result the next cycle with no gap.
  - Non-last beats are always accepted while a result is pending? No: ready_o follows the rule above for all beats, which keeps the logic simple.
- ready_o has no combinational path from valid_i.
- FSM: IDLE (state = INIT, no frame open), ACCUM (at least one beat of the frame accepted), RESULT (crc_valid_o = 1).
  - RESULT and IDLE/ACCUM are tracked independently: the frame state register and the result register are separate.
- valid_i = 0 (or ready_o = 0): no state change; data_i, keep_i and last_i are ignored.
- Single-beat frames (last_i on the first beat) are legal.

Test Plan:
- CRC-8 defaults, BYTES=1, ASCII "123456789" one byte per beat, crc_ready_i = 1 -> crc_o = 0xF4 one cycle after the last beat; crc_valid_o high for 1 cycle.
- CRC-16/CCITT-FALSE (POLYNOMIAL 16'h1021, INIT 16'hFFFF), BYTES=4, "123456789" in beats of keep 1111, 1111, 0001 with last on beat 3 -> crc_o = 0x29B1.
- CRC-32 (04C11DB7, INIT FFFFFFFF, REFLECT_IN/REFLECT_OUT 1, XOR_OUT FFFFFFFF, RESIDUE 2144DF1C), BYTES=4:
  - "123456789" -> crc_o = 0xCBF43926.
  - Same data with 26 39 F4 CB appended -> match_o = 1.
  - Flip one data bit -> match_o = 0.
- Backpressure: hold crc_ready_i = 0 after frame 1 and present frame 2 -> ready_o = 0, crc_o stable; raise crc_ready_i -> frame 2 accepted, both results correct and in order.
- Reset mid-frame: CRC-8, send "1234", pulse rst_i, then send "123456789" -> crc_o = 0xF4; crc_valid_o = 0 during and just after reset.
- Edge beats: keep_i = 0 beat mid-frame and a keep 0101 beat -> result equals reference CRC over the set lanes only.

Source files
------------

// File: rtl/crc_stream.sv
// Streaming CRC engine: folds up to BYTES lanes per beat into a WIDTH-bit CRC and
// presents one result per frame behind a valid/ready result handshake.
module crc_stream #(
    parameter int               WIDTH       = 8,   // 8..32
    parameter logic [WIDTH-1:0] POLYNOMIAL  = WIDTH'(8'h07),
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter logic [WIDTH-1:0] XOR_OUT     = '0,
    parameter logic [WIDTH-1:0] RESIDUE     = '0,
    parameter int               BYTES       = 1    // 1..8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [8*BYTES-1:0]   data_i,
    input  logic [BYTES-1:0]     keep_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [WIDTH-1:0]     crc_o,
    output logic                 match_o,
    output logic                 crc_valid_o,
    input  logic                 crc_ready_i,
    output logic [1:0]           state_o
);

    // Handshakes: a beat moves when valid_i && ready_o; a result moves when
    // crc_valid_o && crc_ready_i. ready_o depends only on registered state and
    // crc_ready_i, never on valid_i.

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } frame_state_t;

    frame_state_t     frame_q;
    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] crc_res_q;
    logic             match_q;
    logic             crc_valid_q;
    logic             accept;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rev_w(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = s[WIDTH-1-i];
        end
        return r;
    endfunction

    // One byte: align to the state MSB, then eight MSB-first division steps.
    function automatic logic [WIDTH-1:0] fold_byte(input logic [WIDTH-1:0] s,
                                                   input logic [7:0]       b);
        logic [7:0]       bb;
        logic [WIDTH-1:0] r;
        bb = REFLECT_IN ? rev8(b) : b;
        r  = s ^ (WIDTH'(bb) << (WIDTH - 8));
        for (int i = 0; i < 8; i++) begin
            if (r[WIDTH-1]) begin
                r = (r << 1) ^ POLYNOMIAL;
            end else begin
                r = r << 1;
            end
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        for (int k = 0; k < BYTES; k++) begin
            if (keep_i[k]) begin
                crc_d = fold_byte(crc_d, data_i[8*k +: 8]);
            end
        end
        result_d = (REFLECT_OUT ? rev_w(crc_d) : crc_d) ^ XOR_OUT;
    end

    assign ready_o = !crc_valid_q || crc_ready_i;
    assign accept  = valid_i && ready_o;

    // Frame state and result register advance independently: a new last beat
    // may land in the same cycle the previous result is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_q     <= IDLE;
            crc_q       <= INIT;
            crc_res_q   <= '0;
            match_q     <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            if (crc_valid_q && crc_ready_i) begin
                crc_valid_q <= 1'b0;
            end
            if (accept) begin
                if (last_i) begin
                    frame_q     <= IDLE;
                    crc_q       <= INIT;
                    crc_res_q   <= result_d;
                    match_q     <= (result_d == RESIDUE);
                    crc_valid_q <= 1'b1;
                end else begin
                    frame_q     <= ACCUM;
                    crc_q       <= crc_d;
                end
            end
        end
    end

    assign crc_o       = crc_res_q;
    assign match_o     = match_q;
    assign crc_valid_o = crc_valid_q;
    assign state_o     = {crc_valid_q, frame_q == ACCUM};

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: three configurations (CRC-8, CRC-16/CCITT-FALSE, CRC-32)
// against a bit-serial reference model, directed test-plan cases plus random frames.
module tb_crc_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] data_v      [3];
    logic [3:0]  keep_v      [3];
    logic        valid_v     [3];
    logic        last_v      [3];
    logic        crc_ready_v [3];
    logic        ready_w     [3];
    logic        match_w     [3];
    logic        cvalid_w    [3];
    logic [1:0]  state_w     [3];
    logic [31:0] crc_w       [3];
    logic [7:0]  crc8;
    logic [15:0] crc16;

    assign crc_w[0] = {24'b0, crc8};
    assign crc_w[1] = {16'b0, crc16};

    crc_stream u_crc8 (
        .clk_i(clk), .rst_i(rst), .data_i(data_v[0][7:0]), .keep_i(keep_v[0][0:0]),
        .valid_i(valid_v[0]), .last_i(last_v[0]), .ready_o(ready_w[0]), .crc_o(crc8),
        .match_o(match_w[0]), .crc_valid_o(cvalid_w[0]), .crc_ready_i(crc_ready_v[0]),
        .state_o(state_w[0])
    );

    crc_stream #(.WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF), .BYTES(4)) u_crc16 (
        .clk_i(clk), .rst_i(rst), .data_i(data_v[1]), .keep_i(keep_v[1]),
        .valid_i(valid_v[1]), .last_i(last_v[1]), .ready_o(ready_w[1]), .crc_o(crc16),
        .match_o(match_w[1]), .crc_valid_o(cvalid_w[1]), .crc_ready_i(crc_ready_v[1]),
        .state_o(state_w[1])
    );

    crc_stream #(.WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                 .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF),
                 .RESIDUE(32'h2144DF1C), .BYTES(4)) u_crc32 (
        .clk_i(clk), .rst_i(rst), .data_i(data_v[2]), .keep_i(keep_v[2]),
        .valid_i(valid_v[2]), .last_i(last_v[2]), .ready_o(ready_w[2]), .crc_o(crc_w[2]),
        .match_o(match_w[2]), .crc_valid_o(cvalid_w[2]), .crc_ready_i(crc_ready_v[2]),
        .state_o(state_w[2])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lanes(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] residue(input int d);
        return (d == 2) ? 32'h2144DF1C : 32'h0;
    endfunction

    // Bit-serial long division over the message, one input bit at a time.
    function automatic logic [31:0] ref_crc(input int d, input logic [7:0] m[$]);
        int          w;
        logic [31:0] poly, r, xo, mask, o;
        bit          ri, ro, fb, bi;
        case (d)
            0:       begin w = 8;  poly = 32'h07;       r = 32'h0;        ri = 0; ro = 0; xo = 32'h0; end
            1:       begin w = 16; poly = 32'h1021;     r = 32'hFFFF;     ri = 0; ro = 0; xo = 32'h0; end
            default: begin w = 32; poly = 32'h04C11DB7; r = 32'hFFFFFFFF; ri = 1; ro = 1; xo = 32'hFFFFFFFF; end
        endcase
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
        foreach (m[i]) begin
            for (int j = 0; j < 8; j++) begin
                bi = ri ? m[i][j] : m[i][7-j];
                fb = r[w-1] ^ bi;
                r  = (r << 1) & mask;
                if (fb) r = r ^ poly;
            end
        end
        if (ro) begin
            o = 32'h0;
            for (int j = 0; j < w; j++) o[j] = r[w-1-j];
            r = o;
        end
        return (r ^ xo) & mask;
    endfunction

    // Cycle-level expectation of each engine's outputs.
    logic [31:0] exp_q [3][$];
    logic [7:0]  msg_q [3][$];
    bit          mv    [3];
    bit          mopen [3];
    bit          mmatch[3];
    logic [31:0] mcrc  [3];
    bit          chk_en = 0;
    bit          rand_ready = 0;
    bit          ready_force [3];

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++)
            crc_ready_v[d] = rand_ready ? 1'($urandom_range(0, 1)) : ready_force[d];
    end

    always @(posedge clk) begin
        logic [31:0] e;
        logic [7:0]  tmp[$];
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mv[d] = 0; mopen[d] = 0; mmatch[d] = 0; mcrc[d] = 32'h0;
                msg_q[d].delete(); exp_q[d].delete();
            end else begin
                if (cvalid_w[d] && crc_ready_v[d]) begin
                    if (exp_q[d].size() == 0) check($sformatf("unexpected_result%0d", d), 32'h1, 32'h0);
                    else check($sformatf("result_order%0d", d), crc_w[d], exp_q[d].pop_front());
                    mv[d] = 0;
                end
                if (valid_v[d] && ready_w[d]) begin
                    for (int k = 0; k < lanes(d); k++)
                        if (keep_v[d][k]) msg_q[d].push_back(data_v[d][8*k +: 8]);
                    if (last_v[d]) begin
                        tmp = msg_q[d];
                        e = ref_crc(d, tmp);
                        exp_q[d].push_back(e);
                        mcrc[d] = e; mmatch[d] = (e == residue(d)); mv[d] = 1; mopen[d] = 0;
                        msg_q[d].delete();
                    end else begin
                        mopen[d] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("crc_valid%0d", d), {31'b0, cvalid_w[d]}, {31'b0, mv[d]});
                check($sformatf("crc%0d", d), crc_w[d], mcrc[d]);
                check($sformatf("ready%0d", d), {31'b0, ready_w[d]}, {31'b0, (!mv[d] || crc_ready_v[d])});
                check($sformatf("state%0d", d), {30'b0, state_w[d]}, {30'b0, mv[d], mopen[d]});
                if (mv[d]) check($sformatf("match%0d", d), {31'b0, match_w[d]}, {31'b0, mmatch[d]});
            end
        end
    end

    logic [7:0] tx_q[$];

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int d, input logic [31:0] dat, input logic [3:0] kp, input logic lst);
        int budget;
        bit done;
        budget = 0; done = 0;
        data_v[d] = dat; keep_v[d] = kp; last_v[d] = lst; valid_v[d] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready_w[d]) begin
                @(posedge clk); done = 1;
            end else begin
                @(posedge clk); budget++;
                if (budget > 200) begin
                    check($sformatf("ready_timeout%0d", d), 32'h0, 32'h1);
                    done = 1;
                end
            end
        end
        #1;
        valid_v[d] = 1'b0; last_v[d] = 1'b0;
    endtask

    task automatic send_buf(input int d);
        logic [31:0] dat;
        logic [3:0]  kp;
        int          i;
        i = 0;
        while (i < tx_q.size()) begin
            dat = 32'h0; kp = 4'h0;
            for (int k = 0; k < lanes(d); k++) begin
                if (i < tx_q.size()) begin
                    dat[8*k +: 8] = tx_q[i]; kp[k] = 1'b1; i++;
                end
            end
            send_beat(d, dat, kp, i >= tx_q.size());
        end
    endtask

    task automatic load_str(input string s);
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    // Called right after the last beat's accepting edge with crc_ready_i = 1.
    task automatic expect_result(input int d, input logic [31:0] lit, input string name);
        @(negedge clk);
        check({name, "_valid"}, {31'b0, cvalid_w[d]}, 32'h1);
        check({name, "_crc"}, crc_w[d], lit);
        @(negedge clk);
        check({name, "_one_cycle"}, {31'b0, cvalid_w[d]}, 32'h0);
        align();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] dat;
        logic [3:0]  kp;
        int          nb;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            data_v[d] = 32'h0; keep_v[d] = 4'h0; valid_v[d] = 1'b0; last_v[d] = 1'b0;
            ready_force[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_crc", crc_w[d], 32'h0);
            check("reset_valid", {31'b0, cvalid_w[d]}, 32'h0);
            check("reset_match", {31'b0, match_w[d]}, 32'h0);
            check("reset_ready", {31'b0, ready_w[d]}, 32'h1);
        end
        align();

        // Reference model pinned to catalogue check values.
        load_str("123456789");
        check("model_crc8", ref_crc(0, tx_q), 32'hF4);
        check("model_crc16", ref_crc(1, tx_q), 32'h29B1);
        check("model_crc32", ref_crc(2, tx_q), 32'hCBF43926);
        tx_q.push_back(8'h26); tx_q.push_back(8'h39); tx_q.push_back(8'hF4); tx_q.push_back(8'hCB);
        check("model_crc32_residue", ref_crc(2, tx_q), 32'h2144DF1C);

        load_str("123456789"); send_buf(0); expect_result(0, 32'hF4, "crc8_check");
        load_str("123456789"); send_buf(1); expect_result(1, 32'h29B1, "crc16_check");
        load_str("123456789"); send_buf(2); expect_result(2, 32'hCBF43926, "crc32_check");

        load_str("123456789");
        tx_q.push_back(8'h26); tx_q.push_back(8'h39); tx_q.push_back(8'hF4); tx_q.push_back(8'hCB);
        send_buf(2);
        @(negedge clk);
        check("crc32_residue_match", {31'b0, match_w[2]}, 32'h1);
        align();
        tx_q[3] = tx_q[3] ^ 8'h04;
        send_buf(2);
        @(negedge clk);
        check("crc32_flip_valid", {31'b0, cvalid_w[2]}, 32'h1);
        check("crc32_flip_match", {31'b0, match_w[2]}, 32'h0);
        align();

        // Backpressure: result pending, second frame must wait.
        ready_force[0] = 1'b0; align();
        load_str("123456789"); send_buf(0);
        load_str("abc");
        fork
            send_buf(0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_ready_low", {31'b0, ready_w[0]}, 32'h0);
                    check("bp_crc_stable", crc_w[0], 32'hF4);
                end
                align();
                ready_force[0] = 1'b1;
            end
        join
        repeat (3) align();

        // Reset discards a pending result and aborts an open frame.
        ready_force[0] = 1'b0; align();
        load_str("123456789"); send_buf(0);
        @(negedge clk);
        check("pending_before_reset", {31'b0, cvalid_w[0]}, 32'h1);
        align();
        rst = 1'b1;
        align();
        @(negedge clk);
        check("valid_during_reset", {31'b0, cvalid_w[0]}, 32'h0);
        align();
        rst = 1'b0;
        @(negedge clk);
        check("valid_after_reset", {31'b0, cvalid_w[0]}, 32'h0);
        ready_force[0] = 1'b1;
        align(); align();
        load_str("1234");
        foreach (tx_q[i]) send_beat(0, {24'h0, tx_q[i]}, 4'h1, 1'b0);
        rst = 1'b1;
        align();
        @(negedge clk);
        check("valid_mid_frame_reset", {31'b0, cvalid_w[0]}, 32'h0);
        align();
        rst = 1'b0;
        align();
        load_str("123456789"); send_buf(0); expect_result(0, 32'hF4, "crc8_after_reset");

        // Empty and sparse keep patterns; only set lanes contribute.
        send_beat(1, 32'h34333231, 4'b1111, 1'b0);
        send_beat(1, 32'hDEADBEEF, 4'b0000, 1'b0);
        send_beat(1, 32'h11223344, 4'b0101, 1'b0);
        send_beat(1, 32'h55667788, 4'b0000, 1'b1);
        tx_q.delete();
        tx_q.push_back(8'h31); tx_q.push_back(8'h32); tx_q.push_back(8'h33);
        tx_q.push_back(8'h34); tx_q.push_back(8'h44); tx_q.push_back(8'h22);
        expect_result(1, ref_crc(1, tx_q), "crc16_sparse_keep");

        // Random frames with random result backpressure.
        rand_ready = 1;
        for (int d = 0; d < 3; d++) begin
            for (int f = 0; f < 40; f++) begin
                nb = $urandom_range(1, 5);
                for (int b = 0; b < nb; b++) begin
                    dat = $urandom;
                    kp  = (lanes(d) == 1) ? {3'b0, 1'($urandom_range(0, 5) != 0)} : 4'($urandom_range(0, 15));
                    send_beat(d, dat, kp, b == nb - 1);
                    repeat ($urandom_range(0, 2)) align();
                end
            end
        end
        rand_ready = 0;
        repeat (6) align();
        for (int d = 0; d < 3; d++) check($sformatf("drained%0d", d), exp_q[d].size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
